// File: rtl/note_pkg.sv
// ============================================================================
//  Module      : note_pkg
//  Description : Shared types and constants for the note playback path:
//                FSM state encoding, default widths and track identifiers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package note_pkg;

    localparam int NOTE_ADDR_W = 6;
    localparam int NOTE_DATA_W = 8;

    localparam logic TRACK1 = 1'b0;
    localparam logic TRACK2 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_NEXT  = 3'd4
    } note_state_t;

    // Mixed runs skip an empty track 1; single-track runs follow sel.
    function automatic logic pick_start_track(
        input logic mix,
        input logic sel,
        input logic lim1_empty
    );
        if (mix) begin
            return lim1_empty ? TRACK2 : TRACK1;
        end
        return sel ? TRACK2 : TRACK1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/note_hold_timer.sv
// ============================================================================
//  Module      : note_hold_timer
//  Description : Counts step_tick enables while a note is sounding and flags
//                the enable that completes NOTE_TICKS of them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_hold_timer #(
    parameter int NOTE_TICKS = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int CNT_W = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NOTE_TICKS - 1);

    logic [CNT_W-1:0] r_count;

    // done is combinational so the FSM can leave HOLD on the final tick itself.
    assign done = enable && (r_count == C_LAST);

    // Tick counter: restarts on clear and after each completed hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear || done) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/note_playback_reader.sv
// ============================================================================
//  Module      : note_playback_reader
//  Description : Reads recorded notes back from the track RAM, one track or
//                track 1 followed by track 2, holding each note for a fixed
//                number of playback ticks and pulsing finish on completion.
//                Build option NOTE_PLAYBACK_LOOP_EN: replay the run from its
//                starting track until stopped instead of finishing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_playback_reader
    import note_pkg::*;
#(
    parameter int ADDR_W     = NOTE_ADDR_W,
    parameter int DATA_W     = NOTE_DATA_W,
    parameter int NOTE_TICKS = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              mix,
    input  logic              sel,
    input  logic              step_tick,
    input  logic [ADDR_W-1:0] limit1,
    input  logic [ADDR_W-1:0] limit2,
    output logic [ADDR_W-1:0] raddr,
    output logic              rd_track,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] note_out,
    output logic              note_valid,
    output logic              busy,
    output logic              finish
);

    note_state_t       r_state;
    note_state_t       w_state_nxt;
    logic [ADDR_W-1:0] r_raddr;
    logic [ADDR_W-1:0] w_raddr_nxt;
    logic              r_rd_track;
    logic              w_rd_track_nxt;
    logic [DATA_W-1:0] r_note_out;
    logic [DATA_W-1:0] w_note_out_nxt;
    logic              r_note_valid;
    logic              w_note_valid_nxt;
    logic              r_finish;
    logic              w_finish_nxt;
    logic              r_mix;
    logic              w_mix_nxt;
    logic [ADDR_W-1:0] r_lim1;
    logic [ADDR_W-1:0] w_lim1_nxt;
    logic [ADDR_W-1:0] r_lim2;
    logic [ADDR_W-1:0] w_lim2_nxt;
`ifdef NOTE_PLAYBACK_LOOP_EN
    logic              r_start_track;
    logic              w_start_track_nxt;
`endif

    logic              w_start_track;
    logic [ADDR_W-1:0] w_start_lim;
    logic [ADDR_W-1:0] w_lim_cur;
    logic [ADDR_W-1:0] w_raddr_inc;
    logic              w_more;
    logic              w_hold_en;
    logic              w_hold_clr;
    logic              w_hold_done;

    // Decisions taken from the live inputs at start time.
    assign w_start_track = pick_start_track(mix, sel, (limit1 == '0));
    assign w_start_lim   = (w_start_track == TRACK2) ? limit2 : limit1;

    // Address advance uses one extra bit so a full-scale limit never wraps.
    assign w_lim_cur   = (r_rd_track == TRACK2) ? r_lim2 : r_lim1;
    assign w_raddr_inc = r_raddr + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign w_more      = ({1'b0, r_raddr} + {{ADDR_W{1'b0}}, 1'b1}) < {1'b0, w_lim_cur};

    // Ticks only count while a note is actually sounding.
    assign w_hold_en  = (r_state == ST_HOLD) && step_tick;
    assign w_hold_clr = (r_state == ST_WAIT);

    note_hold_timer #(
        .NOTE_TICKS (NOTE_TICKS)
    ) u_hold_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (w_hold_clr),
        .enable (w_hold_en),
        .done   (w_hold_done)
    );

    // Next-state and datapath decode; stop outranks every other transition.
    always_comb begin
        w_state_nxt      = r_state;
        w_raddr_nxt      = r_raddr;
        w_rd_track_nxt   = r_rd_track;
        w_note_out_nxt   = r_note_out;
        w_note_valid_nxt = r_note_valid;
        w_finish_nxt     = 1'b0;
        w_mix_nxt        = r_mix;
        w_lim1_nxt       = r_lim1;
        w_lim2_nxt       = r_lim2;
`ifdef NOTE_PLAYBACK_LOOP_EN
        w_start_track_nxt = r_start_track;
`endif

        if (r_state == ST_IDLE) begin
            if (start) begin
                w_mix_nxt  = mix;
                w_lim1_nxt = limit1;
                w_lim2_nxt = limit2;
`ifdef NOTE_PLAYBACK_LOOP_EN
                w_start_track_nxt = w_start_track;
`endif
                if (w_start_lim == '0) begin
                    w_finish_nxt = 1'b1;
                end else begin
                    w_raddr_nxt    = '0;
                    w_rd_track_nxt = w_start_track;
                    w_state_nxt    = ST_FETCH;
                end
            end
        end else if (stop) begin
            w_state_nxt      = ST_IDLE;
            w_note_out_nxt   = '0;
            w_note_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    w_state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    w_note_out_nxt   = rdata;
                    w_note_valid_nxt = 1'b1;
                    w_state_nxt      = ST_HOLD;
                end
                ST_HOLD: begin
                    if (w_hold_done) begin
                        w_note_valid_nxt = 1'b0;
                        w_state_nxt      = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (w_more) begin
                        w_raddr_nxt = w_raddr_inc;
                        w_state_nxt = ST_FETCH;
                    end else if (r_mix && (r_rd_track == TRACK1) && (r_lim2 != '0)) begin
                        w_rd_track_nxt = TRACK2;
                        w_raddr_nxt    = '0;
                        w_state_nxt    = ST_FETCH;
                    end else begin
`ifdef NOTE_PLAYBACK_LOOP_EN
                        w_rd_track_nxt = r_start_track;
                        w_raddr_nxt    = '0;
                        w_state_nxt    = ST_FETCH;
`else
                        w_note_out_nxt   = '0;
                        w_note_valid_nxt = 1'b0;
                        w_finish_nxt     = 1'b1;
                        w_state_nxt      = ST_IDLE;
`endif
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_raddr      <= '0;
            r_rd_track   <= TRACK1;
            r_note_out   <= '0;
            r_note_valid <= 1'b0;
            r_finish     <= 1'b0;
            r_mix        <= 1'b0;
            r_lim1       <= '0;
            r_lim2       <= '0;
`ifdef NOTE_PLAYBACK_LOOP_EN
            r_start_track <= TRACK1;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_raddr      <= w_raddr_nxt;
            r_rd_track   <= w_rd_track_nxt;
            r_note_out   <= w_note_out_nxt;
            r_note_valid <= w_note_valid_nxt;
            r_finish     <= w_finish_nxt;
            r_mix        <= w_mix_nxt;
            r_lim1       <= w_lim1_nxt;
            r_lim2       <= w_lim2_nxt;
`ifdef NOTE_PLAYBACK_LOOP_EN
            r_start_track <= w_start_track_nxt;
`endif
        end
    end

    assign raddr      = r_raddr;
    assign rd_track   = r_rd_track;
    assign note_out   = r_note_out;
    assign note_valid = r_note_valid;
    assign finish     = r_finish;
    assign busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire
